// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: access request fields in, grant and read return out.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_rd_tag_pipe.sv
// Shift register of {valid, owner} that follows each RAM read to its data beat.
module ram_rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [RD_LAT-1:0] valid_sr;
    logic [RD_LAT-1:0] owner_sr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_sr <= '0;
            owner_sr <= {RD_LAT{OWN_A}};
        end else begin
            valid_sr[0] <= in_valid;
            owner_sr[0] <= in_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                owner_sr[i] <= owner_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[RD_LAT-1];
    assign out_owner = owner_sr[RD_LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port RAM between A and B.
// Define ARB_FIXED_PRIO_EN for fixed A priority (A unlimited, B may starve).
//
// state | meaning
// IDLE  | no owner; pick next side (one-cycle gap on every handover)
// GNT_A | A owns the RAM; each cycle with a_req high issues one access
// GNT_B | B owns the RAM; each cycle with b_req high issues one access
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    ram_arbiter_if.slave      a,
    ram_arbiter_if.slave      b,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int            CW   = burst_cnt_w(MAX_BURST);
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    arb_state_t    state;
    logic          last_owner;
    logic          cmd_owner;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] bcnt_inc;
    logic          tie_to_a;
    logic          tag_valid;
    logic          tag_owner;

    // Count saturates so an uncontested owner keeps streaming without a gap.
    always_comb begin
        bcnt_inc = (bcnt == BMAX) ? BMAX : bcnt + CW'(1);
    end

    assign tie_to_a = FIXED_PRIO || (last_owner == OWN_B);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            a.gnt      <= 1'b0;
            b.gnt      <= 1'b0;
            last_owner <= OWN_B;
            cmd_owner  <= OWN_A;
            bcnt       <= '0;
            ram_wr_en  <= 1'b0;
            ram_rd_en  <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    if (a.req && (!b.req || tie_to_a)) begin
                        state <= GNT_A;
                        a.gnt <= 1'b1;
                    end else if (b.req) begin
                        state <= GNT_B;
                        b.gnt <= 1'b1;
                    end
                end
                GNT_A: begin
                    if (!a.req) begin
                        state      <= IDLE;
                        a.gnt      <= 1'b0;
                        last_owner <= OWN_A;
                    end else begin
                        ram_wr_en <= a.we;
                        ram_rd_en <= !a.we;
                        ram_addr  <= a.addr;
                        ram_wdata <= a.we ? a.wdata : '0;
                        cmd_owner <= OWN_A;
                        bcnt      <= bcnt_inc;
                        if (!FIXED_PRIO && (bcnt_inc == BMAX) && b.req) begin
                            state      <= IDLE;
                            a.gnt      <= 1'b0;
                            last_owner <= OWN_A;
                        end
                    end
                end
                GNT_B: begin
                    if (!b.req) begin
                        state      <= IDLE;
                        b.gnt      <= 1'b0;
                        last_owner <= OWN_B;
                    end else begin
                        ram_wr_en <= b.we;
                        ram_rd_en <= !b.we;
                        ram_addr  <= b.addr;
                        ram_wdata <= b.we ? b.wdata : '0;
                        cmd_owner <= OWN_B;
                        bcnt      <= bcnt_inc;
                        if ((bcnt_inc == BMAX) && a.req) begin
                            state      <= IDLE;
                            b.gnt      <= 1'b0;
                            last_owner <= OWN_B;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    a.gnt <= 1'b0;
                    b.gnt <= 1'b0;
                end
            endcase
        end
    end

    ram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (ram_rd_en),
        .in_owner  (cmd_owner),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    assign a.rvalid = tag_valid && (tag_owner == OWN_A);
    assign b.rvalid = tag_valid && (tag_owner == OWN_B);
    assign a.rdata  = a.rvalid ? ram_rdata : '0;
    assign b.rdata  = b.rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference (owner, burst count, RAM array, read-return queue).
module tb_ram_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    ram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .a         (ia),
        .b         (ib),
        .ram_wr_en (ram_wr_en),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            own_b;
    } rd_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: owner 0 none / 1 A / 2 B; last 1 A / 2 B.
    int            m_own  = 0;
    int            m_cnt  = 0;
    int            m_last = 2;
    logic [DW-1:0] mem [256];
    rd_t           rq [$];

    logic          e_a_gnt, e_b_gnt, e_wr, e_rd, e_a_rv, e_b_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_a_rdata, e_b_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic          own_req, oth_req, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        rd_t           r;
        cyc++;
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wdata = '0;
        if (!sys_rst_n) begin
            m_own = 0; m_cnt = 0; m_last = 2;
            rq.delete();
        end else if (m_own == 0) begin
            m_cnt = 0;
            if (ia.req && ib.req)  m_own = (FIXED || m_last == 2) ? 1 : 2;
            else if (ia.req)       m_own = 1;
            else if (ib.req)       m_own = 2;
        end else begin
            own_req = (m_own == 1) ? ia.req : ib.req;
            oth_req = (m_own == 1) ? ib.req : ia.req;
            if (!own_req) begin
                m_last = m_own;
                m_own  = 0;
            end else begin
                we   = (m_own == 1) ? ia.we    : ib.we;
                addr = (m_own == 1) ? ia.addr  : ib.addr;
                wd   = (m_own == 1) ? ia.wdata : ib.wdata;
                e_wr = we; e_rd = !we; e_addr = addr; e_wdata = we ? wd : '0;
                if (we) begin
                    mem[addr] = wd;
                end else begin
                    r.due = cyc + RD_LAT; r.data = mem[addr]; r.own_b = (m_own == 2);
                    rq.push_back(r);
                end
                if (m_cnt < MAX_BURST) m_cnt++;
                if (!(FIXED && m_own == 1) && m_cnt == MAX_BURST && oth_req) begin
                    m_last = m_own;
                    m_own  = 0;
                end
            end
        end
        e_a_gnt = (m_own == 1);
        e_b_gnt = (m_own == 2);
    endtask

    task automatic drive_rdata();
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ram_rdata = rq[0].data;
            e_a_rv = !rq[0].own_b;
            e_b_rv = rq[0].own_b;
        end else begin
            ram_rdata = 8'($urandom);
            e_a_rv = 1'b0;
            e_b_rv = 1'b0;
        end
        e_a_rdata = e_a_rv ? ram_rdata : '0;
        e_b_rdata = e_b_rv ? ram_rdata : '0;
    endtask

    task automatic check_all();
        chk("a_gnt", ia.gnt, e_a_gnt);
        chk("b_gnt", ib.gnt, e_b_gnt);
        chk("ram_wr_en", ram_wr_en, e_wr);
        chk("ram_rd_en", ram_rd_en, e_rd);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("a_rvalid", ia.rvalid, e_a_rv);
        chk("a_rdata", ia.rdata, e_a_rdata);
        chk("b_rvalid", ib.rvalid, e_b_rv);
        chk("b_rdata", ib.rdata, e_b_rdata);
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
        drive_rdata();
        #1;
        check_all();
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        ia.req = req; ia.we = we; ia.addr = addr; ia.wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        ib.req = req; ib.we = we; ib.addr = addr; ib.wdata = wd;
    endtask

    task automatic drive_rand(input logic ar, input logic br);
        drive_a(ar, 1'($urandom), 8'($urandom), 8'($urandom));
        drive_b(br, 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic reset_pulse();
        sys_rst_n = 1'b0;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (2) step();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int k, run, best, drops, rv, bseen;
        bit got;
        logic prev_gnt;
        sys_rst_n = 1'b0;
        ram_rdata = '0;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset held under random requests, then quiet release.
        repeat (6) begin
            step();
            drive_rand(1'($urandom), 1'($urandom));
        end
        sys_rst_n = 1'b1;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (4) step();

        // A alone reads 8'h10.
        drive_a(1'b1, 1'b0, 8'h10, 8'h00);
        step();
        step();
        drive_a(1'b0, 1'b0, '0, '0);
        repeat (6) step();

        // Both continuously requesting from reset.
        reset_pulse();
        repeat (40) begin
            drive_rand(1'b1, 1'b1);
            step();
        end
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (4) step();

        // B alone writes addr 0..19 back to back.
        k = 0; run = 0; best = 0; drops = 0; prev_gnt = 1'b0;
        repeat (30) begin
            drive_b(k < 20, 1'b1, 8'(k), 8'(k));
            if (ib.gnt && ib.req) k++;
            step();
            if (ram_wr_en) run++; else run = 0;
            if (run > best) best = run;
            if (prev_gnt && !ib.gnt && k < 20) drops++;
            prev_gnt = ib.gnt;
        end
        chk("s4_wr_run", best, 20);
        chk("s4_gnt_drop", drops, 0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (4) step();

        // A read, then reset while the read is in flight.
        drive_a(1'b1, 1'b0, 8'($urandom), 8'h00);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ia.gnt) got = 1'b1;
        end
        chk("s5_gnt_seen", got, 1);
        step();
        chk("s5_rd_issued", ram_rd_en, 1);
        drive_a(1'b0, 1'b0, '0, '0);
        sys_rst_n = 1'b0;
        rv = 0;
        repeat (2) begin
            step();
            rv += int'(ia.rvalid);
        end
        sys_rst_n = 1'b1;
        repeat (5) begin
            step();
            rv += int'(ia.rvalid);
        end
        chk("s5_no_rvalid", rv, 0);

        // Both continuous: B starves only under fixed priority.
        reset_pulse();
        bseen = 0;
        repeat (30) begin
            drive_rand(1'b1, 1'b1);
            step();
            bseen += int'(ib.gnt);
        end
        chk("s6_b_starved", (bseen == 0), FIXED);

        // Random traffic.
        repeat (200) begin
            drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            step();
        end
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
